// File: rtl/four_up_counter.sv
// Free-running 4-bit up counter with asynchronous active-high clear and terminal-count flag.
// Build option: FOUR_UP_COUNTER_SATURATE_EN holds the count at 4'hF instead of wrapping.
`timescale 1ns/1ps

module four_up_counter (
  input  logic       clock,
  input  logic       clear,
  output logic [3:0] q,
  output logic       tc
);

  localparam int unsigned W = 4;
  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] q_next;

  // Next count: plain increment wraps naturally at 4 bits unless saturation is built in.
  always_comb begin
    q_next = q + W'(1);
`ifdef FOUR_UP_COUNTER_SATURATE_EN
    if (q == MAX_COUNT) begin
      q_next = MAX_COUNT;
    end
`else
    if (q == MAX_COUNT) begin
      q_next = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // q is forced to zero during clear, so tc drops with it.
  assign tc = (q == MAX_COUNT);

endmodule

// File: tb/tb_four_up_counter.sv
// Self-checking bench for four_up_counter: directed reset/boundary sequences, a vector table,
// and randomized clear pulses checked against an edges-since-clear reference model.
`timescale 1ns/1ps

module tb_four_up_counter;

`ifdef FOUR_UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] q;
  logic       tc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned since   = 0;  // clock edges seen with clear low since the last clear

  typedef struct {
    bit          clr;
    int unsigned edges;
    logic [3:0]  exp_q;
    bit          exp_tc;
  } vec_t;

  vec_t vecs[6];

  four_up_counter dut (
    .clock(clock),
    .clear(clear),
    .q    (q),
    .tc   (tc)
  );

  always #10 clock = ~clock;

  function automatic logic [3:0] model_q(input int unsigned k);
    if (SAT) return (k > 15) ? 4'hF : 4'(k);
    return 4'(k % 16);
  endfunction

  task automatic check(input string name, input logic [3:0] eq, input logic etc);
    n_tests++;
    if (q !== eq || tc !== etc) begin
      n_fail++;
      $display("FAIL %s: got q=%h tc=%b, expected q=%h tc=%b at t=%0t", name, q, tc, eq, etc, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] e;
    e = model_q(since);
    check(name, e, e == 4'hF);
  endtask

  task automatic set_clear(input bit v);
    clear = v;
    if (v) since = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (!clear) since++;
  endtask

  initial begin
    // Reset and first-count timing: clear high ~0..34, first count on the 50 edge
    #1 set_clear(1'b1);
    #4 check("reset_async", 4'h0, 1'b0);
    @(posedge clock); #1 check("clear_hold_e1", 4'h0, 1'b0);
    @(posedge clock); #1 check("clear_hold_e2", 4'h0, 1'b0);
    #3 set_clear(1'b0);
    #6 check("release_no_edge", 4'h0, 1'b0);

    for (int i = 1; i <= 18; i++) begin
      tick();
      check_model("run18");
      if (i == 1)  check("first_edge", 4'h1, 1'b0);
      if (i == 15) check("reach_F", 4'hF, 1'b1);
      if (i == 16) check("after_F", SAT ? 4'hF : 4'h0, SAT);
    end

    // Vector table: {clear level, edges to run, expected q, expected tc} after the last edge
    vecs[0] = '{1'b1, 3, 4'h0, 1'b0};
    vecs[1] = '{1'b0, 1, 4'h1, 1'b0};
    vecs[2] = '{1'b0, 8, 4'h9, 1'b0};
    vecs[3] = '{1'b0, 6, 4'hF, 1'b1};
    vecs[4] = '{1'b0, 1, SAT ? 4'hF : 4'h0, SAT};
    vecs[5] = '{1'b0, 4, SAT ? 4'hF : 4'h4, SAT};
    for (int v = 0; v < 6; v++) begin
      set_clear(vecs[v].clr);
      #1;
      if (vecs[v].clr) check("vec_async_clear", 4'h0, 1'b0);
      for (int e = 0; e < int'(vecs[v].edges); e++) begin
        tick();
        check_model("vec_step");
      end
      check($sformatf("vec%0d", v), vecs[v].exp_q, vecs[v].exp_tc);
    end

    // Mid-count clear between edges: count to 9, clear, release, resume at 1
    set_clear(1'b1);
    tick();
    set_clear(1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("count_to_9", 4'h9, 1'b0);
    #5 set_clear(1'b1);
    #1 check("mid_clear_async", 4'h0, 1'b0);
    #4 set_clear(1'b0);
    tick();
    check("resume_after_mid_clear", 4'h1, 1'b0);

    // Clear rising exactly on a clock edge dominates
    tick(); tick();
    @(posedge clock);
    set_clear(1'b1);
    #1 check("coincident_clear", 4'h0, 1'b0);
    @(negedge clock);
    set_clear(1'b0);
    tick();
    check("after_coincident", 4'h1, 1'b0);

    // Randomized clear activity against the model
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 7) == 0);
      #($urandom_range(2, 8));
      set_clear(v);
      if (v) begin
        #1 check("rand_async_clear", 4'h0, 1'b0);
      end
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/four_up_counter.md
FOUR_UP_COUNTER -- requirements
Module: four_up_counter

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 4 bits.
REQ-002 Port: clock  input  1  single clock, all state changes on rising edge except clear.
REQ-003 Port: clear  input  1  reset, asynchronous, active-high.
REQ-004 Port: q  output  4  current count value, registered.
REQ-005 Port: tc  output  1  terminal count flag, high when q == 4'hF, combinational from q.
REQ-006 The block SHALL have exactly one clock (clock) and one reset (clear); clear SHALL be asynchronous and active-high.

Function
REQ-007 On each rising edge of clock with clear low, q SHALL become (q + 1) mod 16 (one-cycle latency, no enable).
REQ-008 With macro FOUR_UP_COUNTER_SATURATE_EN undefined, q = 4'hF SHALL wrap to 4'h0 on the next rising edge.
REQ-009 tc SHALL equal 1 exactly while q == 4'hF, and 0 otherwise, including during clear.
REQ-010 Arithmetic SHALL be unsigned 4-bit; no carry is stored beyond q.
REQ-011 Output q SHALL be driven only by flip-flops; no glitches from combinational logic on q.
REQ-012 A rising clock edge coincident with clear high SHALL leave q at 0 (clear dominates).

Reset
REQ-013 When clear is high, q SHALL go to 4'h0 immediately, without waiting for a clock edge, and SHALL remain 0 while clear stays high.
REQ-014 While clear is high, tc SHALL be 0.
REQ-015 After clear falls, the first rising clock edge SHALL load q = 4'h1; clear deassertion SHALL need no synchronizer inside this block.
REQ-016 Asserting clear mid-count SHALL abort the count and force q = 0 asynchronously; counting resumes from 0 after release.

Configuration
REQ-017 Macro FOUR_UP_COUNTER_SATURATE_EN: when defined, q SHALL hold at 4'hF once reached (no wrap), and only clear SHALL return it to 0.
REQ-018 When FOUR_UP_COUNTER_SATURATE_EN is undefined, the counter SHALL wrap modulo 16 per REQ-008.
REQ-019 tc behaviour SHALL be identical in both configurations.

Verification
REQ-020 Clock period 20 units, clear high 0..34, then low -> q = 0 up to t=34; q = 1 after posedge t=50, q increments by 1 each following posedge.
REQ-021 Count 15 posedges after clear release -> q = 4'hF and tc = 1; next posedge -> q = 4'h0, tc = 0 (saturate macro off).
REQ-022 Same stimulus with FOUR_UP_COUNTER_SATURATE_EN defined -> q stays 4'hF and tc stays 1 for 5 further posedges.
REQ-023 Count to q = 4'h9, assert clear between clock edges -> q = 0 before the next posedge; release -> q = 1 after the following posedge.
REQ-024 Hold clear high across 3 posedges -> q stays 0 and tc stays 0 throughout.
REQ-025 Run 18 posedges from release (400-unit run) -> q sequence 1..F,0,1,2 with no skipped or repeated values.
